burst_rw_sched: RTL and testbench

Parametrised CAS-to-data burst scheduler, the multi-command successor to the single-command read/write burst FSM. It sits between the CAS command stage and the data-path driver. Every accepted READ/WRITE CAS is queued with its own latency countdown (CL or CWL), and the block emits per-burst data-phase strobes in command order. It supports BL8 and on-the-fly BC4 bursts, seamless back-to-back bursts, and sticky error reporting.

---
 rtl/burst_rw_sched.sv | 184 ++++++++++++++++++
 tb/tb_burst_rw_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_rw_sched.sv
// CAS-to-data burst scheduler: queues READ/WRITE CAS commands with per-entry latency
// countdowns and emits in-order data-phase strobes. RW_TURNAROUND_EN adds a read/write gap cycle.
//
// state   | meaning
// D_IDLE  | bus free, waiting for the head entry to come due
// D_BURST | data phase running, bcnt holds the cycles left including this one
// D_GAP   | one-cycle read/write turnaround bubble (RW_TURNAROUND_EN only)
module burst_rw_sched #(
    parameter int DEPTH   = 8,
    parameter int LAT_W   = 6,
    parameter int BL8_CYC = 4,
    parameter int BC4_CYC = 2
) (
    input  logic                         clock_t,
    input  logic                         reset,
    input  logic                         cas_rdy,
    input  logic [1:0]                   cas_rw,
    input  logic                         cas_bc4,
    input  logic [LAT_W-1:0]             rd_delay,
    input  logic [LAT_W-1:0]             wr_delay,
    input  logic                         err_clr,
    output logic                         rw_rdy,
    output logic [1:0]                   rw_act,
    output logic                         data_valid,
    output logic                         rw_done,
    output logic                         data_idle,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         full,
    output logic                         overflow,
    output logic                         late,
    output logic                         cmd_err
);

    localparam int PW    = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int BMAX  = (BL8_CYC > BC4_CYC) ? BL8_CYC : BC4_CYC;
    localparam int BW    = $clog2(BMAX + 1);
    localparam logic [1:0] CMD_RD = 2'b01;
    localparam logic [1:0] CMD_WR = 2'b10;

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_BURST = 2'd1
`ifdef RW_TURNAROUND_EN
        , D_GAP = 2'd2
`endif
    } dstate_t;

    dstate_t          state;
    logic [BW-1:0]    bcnt;
    logic [1:0]       q_typ [DEPTH];
    logic             q_bc4 [DEPTH];
    logic [LAT_W-1:0] q_cnt [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;

    logic             head_valid, head_due, cmd_ok, queue_full;
    logic             start, go_gap, accept, drop;
    logic [LAT_W-1:0] head_cnt, lat_sel, lat_eff;
    logic [BW-1:0]    len_head;
    logic [PW-1:0]    pend_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // An entry written with latency D reaches 2 in the cycle before its due edge.
    assign head_valid = (pending != '0);
    assign head_cnt   = q_cnt[rd_ptr];
    assign head_due   = head_valid && (head_cnt <= LAT_W'(2));
    assign len_head   = q_bc4[rd_ptr] ? BW'(BC4_CYC) : BW'(BL8_CYC);
    assign cmd_ok     = (cas_rw == CMD_RD) || (cas_rw == CMD_WR);
    assign queue_full = (pending == PW'(DEPTH));
    assign lat_sel    = (cas_rw == CMD_RD) ? rd_delay : wr_delay;
    assign lat_eff    = (lat_sel < LAT_W'(2)) ? LAT_W'(2) : lat_sel;

    always_comb begin
        start  = 1'b0;
        go_gap = 1'b0;
        case (state)
            D_IDLE: start = head_due;
            D_BURST: begin
                if (bcnt == BW'(1) && head_due) begin
`ifdef RW_TURNAROUND_EN
                    if (q_typ[rd_ptr] != rw_act) go_gap = 1'b1;
                    else                         start  = 1'b1;
`else
                    start = 1'b1;
`endif
                end
            end
`ifdef RW_TURNAROUND_EN
            D_GAP: start = head_valid;
`endif
            default: ;
        endcase
    end

    // A full queue still takes a CAS when the head leaves on the same edge.
    assign accept = cas_rdy && cmd_ok && (!queue_full || start);
    assign drop   = cas_rdy && cmd_ok && queue_full && !start;

    always_comb begin
        pend_nxt = pending;
        if (accept && !start)      pend_nxt = pending + 1'b1;
        else if (!accept && start) pend_nxt = pending - 1'b1;
    end

    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            pending <= '0;
            full    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_typ[i] <= 2'b00;
                q_bc4[i] <= 1'b0;
                q_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++)
                q_cnt[i] <= (q_cnt[i] == '0) ? '0 : q_cnt[i] - 1'b1;
            if (accept) begin
                q_typ[wr_ptr] <= cas_rw;
                q_bc4[wr_ptr] <= cas_bc4;
                q_cnt[wr_ptr] <= lat_eff;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (start) rd_ptr <= ptr_inc(rd_ptr);
            pending <= pend_nxt;
            full    <= (pend_nxt == PW'(DEPTH));
        end
    end

    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            state      <= D_IDLE;
            bcnt       <= '0;
            rw_rdy     <= 1'b0;
            rw_act     <= 2'b00;
            data_valid <= 1'b0;
            rw_done    <= 1'b0;
            data_idle  <= 1'b1;
        end else begin
            rw_rdy  <= 1'b0;
            rw_done <= 1'b0;
            if (start) begin
                state      <= D_BURST;
                bcnt       <= len_head;
                rw_rdy     <= 1'b1;
                rw_act     <= q_typ[rd_ptr];
                data_valid <= 1'b1;
                rw_done    <= (len_head == BW'(1));
                data_idle  <= 1'b0;
            end else if (state == D_BURST && bcnt != BW'(1)) begin
                bcnt      <= bcnt - 1'b1;
                rw_done   <= (bcnt == BW'(2));
                data_idle <= 1'b0;
            end else begin
`ifdef RW_TURNAROUND_EN
                state <= go_gap ? D_GAP : D_IDLE;
`else
                state <= D_IDLE;
`endif
                rw_act     <= 2'b00;
                data_valid <= 1'b0;
                data_idle  <= !go_gap && (pend_nxt == '0);
            end
        end
    end

    // Sticky flags: a fresh error in the err_clr cycle keeps its flag set.
    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            late     <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            overflow <= drop | (overflow & ~err_clr);
            late     <= (start && head_cnt < LAT_W'(2)) | (late & ~err_clr);
            cmd_err  <= (cas_rdy && !cmd_ok) | (cmd_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_burst_rw_sched.sv
// Directed bench for burst_rw_sched (DEPTH=4); expected bus windows are hand-computed per test,
// with the turnaround case following RW_TURNAROUND_EN.
module tb_burst_rw_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cas_rdy = 1'b0;
    logic [1:0] cas_rw = 2'b00;
    logic       cas_bc4 = 1'b0;
    logic [5:0] rd_delay = 6'd0;
    logic [5:0] wr_delay = 6'd0;
    logic       err_clr = 1'b0;
    logic       rw_rdy, data_valid, rw_done, data_idle, full, overflow, late, cmd_err;
    logic [1:0] rw_act;
    logic [2:0] pending;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int test_id = 0;

    int         n_cas;
    int         cs_c  [8];
    logic [1:0] cs_rw [8];
    logic       cs_b  [8];
    int         clr_c [2];
    logic [5:0] rd_d, wr_d;
    int         nb;
    int         bs [8];
    int         bl [8];
    logic [1:0] bt [8];

    burst_rw_sched #(.DEPTH(4), .LAT_W(6), .BL8_CYC(4), .BC4_CYC(2)) dut (
        .clock_t(clk), .reset(reset), .cas_rdy(cas_rdy), .cas_rw(cas_rw), .cas_bc4(cas_bc4),
        .rd_delay(rd_delay), .wr_delay(wr_delay), .err_clr(err_clr),
        .rw_rdy(rw_rdy), .rw_act(rw_act), .data_valid(data_valid), .rw_done(rw_done),
        .data_idle(data_idle), .pending(pending), .full(full), .overflow(overflow),
        .late(late), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL t%0d c%0d %s observed %0h expected %0h", test_id, cyc, tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst rw_rdy", 32'(rw_rdy), 0);
        chk("rst data_valid", 32'(data_valid), 0);
        chk("rst rw_done", 32'(rw_done), 0);
        chk("rst rw_act", 32'(rw_act), 0);
        chk("rst data_idle", 32'(data_idle), 1);
        chk("rst pending", 32'(pending), 0);
        chk("rst full", 32'(full), 0);
        chk("rst overflow", 32'(overflow), 0);
        chk("rst late", 32'(late), 0);
        chk("rst cmd_err", 32'(cmd_err), 0);
    endtask

    task automatic new_test(input int id, input logic [5:0] rd, input logic [5:0] wr);
        test_id  = id;
        n_cas    = 0;
        nb       = 0;
        clr_c[0] = -1;
        clr_c[1] = -1;
        rd_d     = rd;
        wr_d     = wr;
        cas_rdy  = 1'b0;
        err_clr  = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    task automatic add_cas(input int c, input logic [1:0] rw, input logic b);
        cs_c[n_cas]  = c;
        cs_rw[n_cas] = rw;
        cs_b[n_cas]  = b;
        n_cas++;
    endtask

    task automatic add_burst(input int s, input int len, input logic [1:0] t);
        bs[nb] = s;
        bl[nb] = len;
        bt[nb] = t;
        nb++;
    endtask

    task automatic check_bus();
        logic       e_rdy, e_dv, e_done;
        logic [1:0] e_act;
        e_rdy = 0; e_dv = 0; e_done = 0; e_act = 2'b00;
        for (int i = 0; i < nb; i++) begin
            if (cyc == bs[i]) e_rdy = 1;
            if (cyc >= bs[i] && cyc < bs[i] + bl[i]) begin
                e_dv  = 1;
                e_act = bt[i];
            end
            if (cyc == bs[i] + bl[i] - 1) e_done = 1;
        end
        chk("rw_rdy", 32'(rw_rdy), 32'(e_rdy));
        chk("data_valid", 32'(data_valid), 32'(e_dv));
        chk("rw_done", 32'(rw_done), 32'(e_done));
        chk("rw_act", 32'(rw_act), 32'(e_act));
    endtask

    // Drives the inputs for the current cycle, steps one edge, then checks the bus.
    task automatic run_to(input int c_end);
        while (cyc < c_end) begin
            rd_delay = rd_d;
            wr_delay = wr_d;
            cas_rdy  = 1'b0;
            for (int i = 0; i < n_cas; i++)
                if (cs_c[i] == cyc) begin
                    cas_rdy = 1'b1;
                    cas_rw  = cs_rw[i];
                    cas_bc4 = cs_b[i];
                end
            err_clr = (cyc == clr_c[0]) || (cyc == clr_c[1]);
            @(posedge clk);
            #1;
            cyc++;
            cas_rdy = 1'b0;
            err_clr = 1'b0;
            check_bus();
        end
    endtask

    initial begin
        // reset values while reset is held
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals();

        // single read, CL=11, BL8
        new_test(1, 6'd11, 6'd11);
        add_cas(0, 2'b01, 1'b0);
        add_burst(11, 4, 2'b01);
        run_to(1);
        chk("pending after cas", 32'(pending), 1);
        chk("data_idle queued", 32'(data_idle), 0);
        run_to(11);
        chk("pending at rw_rdy", 32'(pending), 0);
        run_to(14);
        chk("data_idle at done", 32'(data_idle), 0);
        run_to(15);
        chk("data_idle after done", 32'(data_idle), 1);
        chk("late single", 32'(late), 0);

        // seamless reads at 0 and 4
        new_test(2, 6'd11, 6'd11);
        add_cas(0, 2'b01, 1'b0);
        add_cas(4, 2'b01, 1'b0);
        add_burst(11, 4, 2'b01);
        add_burst(15, 4, 2'b01);
        run_to(5);
        chk("pending two", 32'(pending), 2);
        run_to(20);
        chk("late seamless", 32'(late), 0);
        chk("data_idle seamless", 32'(data_idle), 1);

        // collision: second read pushed from 13 to 15
        new_test(3, 6'd11, 6'd11);
        add_cas(0, 2'b01, 1'b0);
        add_cas(2, 2'b01, 1'b0);
        clr_c[0] = 20;
        add_burst(11, 4, 2'b01);
        add_burst(15, 4, 2'b01);
        run_to(16);
        chk("late collision", 32'(late), 1);
        run_to(20);
        chk("late held", 32'(late), 1);
        run_to(21);
        chk("late cleared", 32'(late), 0);

        // overflow with DEPTH=4, plus a CAS accepted at full as the head leaves
        new_test(4, 6'd20, 6'd20);
        for (int i = 0; i < 5; i++) add_cas(i, 2'b01, 1'b0);
        add_cas(19, 2'b01, 1'b0);
        add_burst(20, 4, 2'b01);
        add_burst(24, 4, 2'b01);
        add_burst(28, 4, 2'b01);
        add_burst(32, 4, 2'b01);
        add_burst(39, 4, 2'b01);
        run_to(4);
        chk("pending full", 32'(pending), 4);
        chk("full set", 32'(full), 1);
        chk("overflow before drop", 32'(overflow), 0);
        run_to(5);
        chk("overflow after drop", 32'(overflow), 1);
        chk("pending after drop", 32'(pending), 4);
        chk("late before start", 32'(late), 0);
        run_to(20);
        chk("pending enq+deq", 32'(pending), 4);
        chk("full enq+deq", 32'(full), 1);
        run_to(24);
        chk("pending after 2nd", 32'(pending), 3);
        chk("full after 2nd", 32'(full), 0);
        chk("late queued burst", 32'(late), 1);
        run_to(44);
        chk("pending drained", 32'(pending), 0);
        chk("data_idle drained", 32'(data_idle), 1);

        // BC4 write, invalid command types, err_clr against a same-cycle error
        new_test(5, 6'd11, 6'd9);
        add_cas(0, 2'b10, 1'b1);
        add_cas(1, 2'b11, 1'b0);
        add_cas(3, 2'b00, 1'b0);
        clr_c[0] = 3;
        clr_c[1] = 5;
        add_burst(9, 2, 2'b10);
        run_to(2);
        chk("cmd_err set", 32'(cmd_err), 1);
        chk("pending no enqueue", 32'(pending), 1);
        run_to(4);
        chk("cmd_err error wins", 32'(cmd_err), 1);
        chk("pending still one", 32'(pending), 1);
        run_to(6);
        chk("cmd_err cleared", 32'(cmd_err), 0);
        run_to(11);
        chk("data_idle bc4", 32'(data_idle), 1);
        chk("overflow untouched", 32'(overflow), 0);

        // read then write: turnaround gap when enabled
        new_test(6, 6'd11, 6'd11);
        add_cas(0, 2'b01, 1'b0);
        add_cas(4, 2'b10, 1'b0);
        add_burst(11, 4, 2'b01);
`ifdef RW_TURNAROUND_EN
        add_burst(16, 4, 2'b10);
        run_to(21);
        chk("late turnaround", 32'(late), 1);
`else
        add_burst(15, 4, 2'b10);
        run_to(21);
        chk("late no turnaround", 32'(late), 0);
`endif
        chk("data_idle rw", 32'(data_idle), 1);

        // reset in the middle of a burst with a second entry queued
        new_test(7, 6'd11, 6'd11);
        add_cas(0, 2'b01, 1'b0);
        add_cas(2, 2'b01, 1'b0);
        add_burst(11, 4, 2'b01);
        run_to(12);
        chk("pre-reset pending", 32'(pending), 1);
        reset = 1'b1;
        #1;
        chk_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
        end
        chk("post-reset data_valid", 32'(data_valid), 0);
        chk("post-reset rw_done", 32'(rw_done), 0);
        chk("post-reset data_idle", 32'(data_idle), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
